// File: rtl/fifo_write_arbiter_if.sv
// Write-side bus between the requesters, the FIFO write port and the
// round-robin arbiter.
//   master : the arbiter (drives ready/grant/FIFO write side/status)
//   slave  : requesters + FIFO full logic (drive valid/data/flag_full)
// Signals:
//   req_valid/req_data/req_ready : per-requester handshake, data packed
//                                  with slice i = [i*DATA_W +: DATA_W]
//   flag_full                    : FIFO full flag
//   w_en/data_write              : FIFO write port
//   grant/grant_id/busy          : current owner (one-hot / binary) and burst flag
//   word_count                   : saturating count of words written
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int REQ_BIT = 2,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      flag_full;
    logic                      w_en;
    logic [DATA_W-1:0]         data_write;
    logic [NUM_REQ-1:0]        grant;
    logic [REQ_BIT-1:0]        grant_id;
    logic                      busy;
    logic [CNT_W-1:0]          word_count;

    modport master (
        input  req_valid, req_data, flag_full,
        output req_ready, w_en, data_write, grant, grant_id, busy, word_count
    );

    modport slave (
        output req_valid, req_data, flag_full,
        input  req_ready, w_en, data_write, grant, grant_id, busy, word_count
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ
// requesters in the write clock domain. A winner owns the port for a burst
// of up to BURST_LEN words; transfers are gated by flag_full every cycle.
// Ports:
//   w_clk : write-domain clock
//   w_rst : synchronous active-high reset
//   bus   : fifo_write_arbiter_if.master (handshake, FIFO write, status)
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int REQ_BIT   = 2,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 w_clk,
    input  logic                 w_rst,
    fifo_write_arbiter_if.master bus
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [REQ_BIT-1:0] LAST_ID   = REQ_BIT'(NUM_REQ - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [REQ_BIT-1:0]  grant_id_q, grant_id_d;
    logic                busy_q, busy_d;
    logic [REQ_BIT-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [DATA_W-1:0]   words [NUM_REQ];
    logic                pick_found;
    logic [REQ_BIT-1:0]  pick_id;
    logic                owner_valid;
    logic                xfer;
    logic [REQ_BIT-1:0]  next_ptr;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            words[i] = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        int unsigned idx_w;
        pick_found = 1'b0;
        pick_id    = '0;
        idx_w      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx_w = 32'(rr_ptr_q) + i;
            if (idx_w >= NUM_REQ) begin
                idx_w = idx_w - NUM_REQ;
            end
            if (!pick_found && bus.req_valid[REQ_BIT'(idx_w)]) begin
                pick_found = 1'b1;
                pick_id    = REQ_BIT'(idx_w);
            end
        end
    end

    assign owner_valid = bus.req_valid[grant_id_q];
    // Reset is folded in so nothing is written or acknowledged in a reset cycle.
    assign xfer     = (state_q == BURST) && owner_valid && !bus.flag_full && !w_rst;
    assign next_ptr = (grant_id_q == LAST_ID) ? '0 : grant_id_q + REQ_BIT'(1);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        rr_ptr_d   = rr_ptr_q;
        beat_d     = beat_q;
        data_d     = xfer ? words[grant_id_q] : data_q;
        count_d    = (xfer && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d          = BURST;
                    grant_d          = '0;
                    grant_d[pick_id] = 1'b1;
                    grant_id_d       = pick_id;
                    busy_d           = 1'b1;
                    beat_d           = '0;
                end
            end
            BURST: begin
                // Release on the last beat, or early when the owner drops valid
                // while the FIFO has room; a full FIFO freezes everything.
                if ((xfer && (beat_q == LAST_BEAT)) || (!owner_valid && !bus.flag_full)) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = next_ptr;
                end else if (xfer) begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= '0;
            beat_q     <= '0;
            data_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_q     <= beat_d;
            data_q     <= data_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = xfer && (REQ_BIT'(i) == grant_id_q);
        end
    end

    assign bus.w_en       = xfer;
    assign bus.data_write = xfer ? words[grant_id_q] : data_q;
    assign bus.grant      = grant_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = busy_q;
    assign bus.word_count = count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

    logic w_clk;
    logic w_rst;
    logic rst4;
    int   checks;
    int   errors;

    fifo_write_arbiter_if #(.NUM_REQ(4), .REQ_BIT(2), .DATA_W(8), .CNT_W(16)) bus ();
    fifo_write_arbiter_if #(.NUM_REQ(4), .REQ_BIT(2), .DATA_W(8), .CNT_W(4))  bus4 ();

    fifo_write_arbiter #(.NUM_REQ(4), .REQ_BIT(2), .DATA_W(8), .BURST_LEN(4), .CNT_W(16)) u_dut (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .bus   (bus)
    );

    fifo_write_arbiter #(.NUM_REQ(4), .REQ_BIT(2), .DATA_W(8), .BURST_LEN(4), .CNT_W(4)) u_dut4 (
        .w_clk (w_clk),
        .w_rst (rst4),
        .bus   (bus4)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic do_reset();
        w_rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.flag_full = 1'b0;
        step();
        step();
        w_rst = 1'b0;
    endtask

    task automatic test_reset();
        w_rst = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'hDDCCBBAA;
        bus.flag_full = 1'b0;
        step();
        step();
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b expected 0000", bus.grant); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: got %0d expected 0", bus.grant_id); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.word_count !== 16'd0) begin errors++; $display("FAIL rst_word_count: got %h expected 0000", bus.word_count); end
        checks++; if (bus.w_en !== 1'b0) begin errors++; $display("FAIL rst_w_en: got %b expected 0", bus.w_en); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b expected 0000", bus.req_ready); end
    endtask

    // Requester 0 alone: two back-to-back bursts of 4 with one idle cycle.
    task automatic test_single();
        int k;
        int wr;
        logic exp_we;
        logic [3:0] exp_g;
        do_reset();
        k = 0; wr = 0;
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = 4'b0001;
            bus.req_data  = {24'h0, 8'(8'h10 + k)};
            bus.flag_full = 1'b0;
            #1;
            exp_we = (c != 0) && (c != 5);
            exp_g  = exp_we ? 4'b0001 : 4'b0000;
            checks++; if (bus.w_en !== exp_we) begin errors++; $display("FAIL single_w_en c=%0d: got %b expected %b", c, bus.w_en, exp_we); end
            checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL single_grant c=%0d: got %b expected %b", c, bus.grant, exp_g); end
            checks++; if (bus.req_ready !== exp_g) begin errors++; $display("FAIL single_ready c=%0d: got %b expected %b", c, bus.req_ready, exp_g); end
            checks++; if (bus.word_count !== 16'(wr)) begin errors++; $display("FAIL single_count c=%0d: got %0d expected %0d", c, bus.word_count, wr); end
            if (exp_we) begin
                checks++; if (bus.data_write !== 8'(8'h10 + wr)) begin errors++; $display("FAIL single_data c=%0d: got %h expected %h", c, bus.data_write, 8'(8'h10 + wr)); end
                wr++;
            end
            if (bus.req_ready[0]) k++;
            step();
        end
        bus.req_valid = '0;
        #1;
        checks++; if (bus.word_count !== 16'd8) begin errors++; $display("FAIL single_total: got %0d expected 8", bus.word_count); end
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL single_end_grant: got %b expected 0000", bus.grant); end
    endtask

    // All four requesting: owners 0,1,2,3,0, four writes each, one idle between.
    task automatic test_round_robin();
        int owner;
        logic exp_we;
        logic [3:0] exp_g;
        do_reset();
        for (int c = 0; c < 25; c++) begin
            bus.req_valid = 4'b1111;
            bus.req_data  = 32'hA3A2A1A0;
            bus.flag_full = 1'b0;
            #1;
            owner  = (c / 5) % 4;
            exp_we = (c % 5) != 0;
            exp_g  = exp_we ? 4'(1 << owner) : 4'b0000;
            checks++; if (bus.w_en !== exp_we) begin errors++; $display("FAIL rr_w_en c=%0d: got %b expected %b", c, bus.w_en, exp_we); end
            checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, bus.grant, exp_g); end
            checks++; if (bus.req_ready !== exp_g) begin errors++; $display("FAIL rr_ready c=%0d: got %b expected %b", c, bus.req_ready, exp_g); end
            if (exp_we) begin
                checks++; if (bus.grant_id !== 2'(owner)) begin errors++; $display("FAIL rr_grant_id c=%0d: got %0d expected %0d", c, bus.grant_id, owner); end
                checks++; if (bus.data_write !== 8'(8'hA0 + owner)) begin errors++; $display("FAIL rr_data c=%0d: got %h expected %h", c, bus.data_write, 8'(8'hA0 + owner)); end
            end
            step();
        end
        bus.req_valid = '0;
        #1;
        checks++; if (bus.word_count !== 16'd20) begin errors++; $display("FAIL rr_total: got %0d expected 20", bus.word_count); end
    endtask

    // Requester 2 stalled by full for 3 cycles after its 2nd word; valid dips during the stall.
    task automatic test_full_stall();
        int k;
        int wr;
        logic exp_we;
        logic [3:0] exp_g;
        do_reset();
        k = 0; wr = 0;
        for (int c = 0; c < 9; c++) begin
            bus.req_valid = (c == 4) ? 4'b0000 : 4'b0100;
            bus.req_data  = {8'h00, 8'(8'h30 + k), 16'h0000};
            bus.flag_full = (c >= 3) && (c <= 5);
            #1;
            exp_we = (c == 1) || (c == 2) || (c == 6) || (c == 7);
            exp_g  = ((c >= 1) && (c <= 7)) ? 4'b0100 : 4'b0000;
            checks++; if (bus.w_en !== exp_we) begin errors++; $display("FAIL full_w_en c=%0d: got %b expected %b", c, bus.w_en, exp_we); end
            checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL full_grant c=%0d: got %b expected %b", c, bus.grant, exp_g); end
            checks++; if (bus.busy !== (exp_g != 4'b0000)) begin errors++; $display("FAIL full_busy c=%0d: got %b expected %b", c, bus.busy, exp_g != 4'b0000); end
            checks++; if (bus.req_ready !== (exp_we ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL full_ready c=%0d: got %b expected %b", c, bus.req_ready, exp_we ? 4'b0100 : 4'b0000); end
            if (exp_we) begin
                checks++; if (bus.data_write !== 8'(8'h30 + wr)) begin errors++; $display("FAIL full_data c=%0d: got %h expected %h", c, bus.data_write, 8'(8'h30 + wr)); end
                wr++;
            end
            if (bus.flag_full) begin
                checks++; if (bus.data_write !== 8'h31) begin errors++; $display("FAIL full_hold c=%0d: got %h expected 31", c, bus.data_write); end
            end
            if (bus.req_ready[2]) k++;
            step();
        end
        checks++; if (bus.word_count !== 16'd4) begin errors++; $display("FAIL full_total: got %0d expected 4", bus.word_count); end
    endtask

    // Requester 1 releases early after 2 words; rr_ptr=2 then favours 3 over 1.
    task automatic test_early_release();
        int k1;
        int k3;
        int w1;
        int w3;
        int owner;
        logic exp_we;
        logic [3:0] exp_g;
        do_reset();
        k1 = 0; k3 = 0; w1 = 0; w3 = 0;
        for (int c = 0; c < 11; c++) begin
            bus.req_valid = {1'b1, 1'b0, ((c <= 2) || (c >= 4)), 1'b0};
            bus.req_data  = {8'(8'h60 + k3), 8'h00, 8'(8'h40 + k1), 8'h00};
            bus.flag_full = 1'b0;
            #1;
            owner  = ((c >= 5) && (c <= 8)) ? 3 : 1;
            exp_we = (c == 1) || (c == 2) || ((c >= 5) && (c <= 8)) || (c == 10);
            exp_g  = ((c >= 1) && (c <= 3)) || (c == 10) ? 4'b0010 :
                     ((c >= 5) && (c <= 8)) ? 4'b1000 : 4'b0000;
            checks++; if (bus.w_en !== exp_we) begin errors++; $display("FAIL early_w_en c=%0d: got %b expected %b", c, bus.w_en, exp_we); end
            checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL early_grant c=%0d: got %b expected %b", c, bus.grant, exp_g); end
            checks++; if (bus.req_ready !== (exp_we ? exp_g : 4'b0000)) begin errors++; $display("FAIL early_ready c=%0d: got %b expected %b", c, bus.req_ready, exp_we ? exp_g : 4'b0000); end
            if (exp_we) begin
                if (owner == 3) begin
                    checks++; if (bus.data_write !== 8'(8'h60 + w3)) begin errors++; $display("FAIL early_data3 c=%0d: got %h expected %h", c, bus.data_write, 8'(8'h60 + w3)); end
                    w3++;
                end else begin
                    checks++; if (bus.data_write !== 8'(8'h40 + w1)) begin errors++; $display("FAIL early_data1 c=%0d: got %h expected %h", c, bus.data_write, 8'(8'h40 + w1)); end
                    w1++;
                end
            end
            if (bus.req_ready[1]) k1++;
            if (bus.req_ready[3]) k3++;
            step();
        end
        bus.req_valid = '0;
    endtask

    // Reset mid-burst at beat 2 with valid high, after a burst left rr_ptr=2.
    task automatic test_reset_mid_burst();
        logic exp_we;
        logic [3:0] exp_g;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = (c <= 4) ? 4'b0010 : 4'b0001;
            bus.req_data  = 32'h0000_5150;
            bus.flag_full = 1'b0;
            #1;
            exp_we = ((c >= 1) && (c <= 4)) || (c >= 6);
            exp_g  = ((c >= 1) && (c <= 4)) ? 4'b0010 : (c >= 6) ? 4'b0001 : 4'b0000;
            checks++; if (bus.w_en !== exp_we) begin errors++; $display("FAIL mid_w_en c=%0d: got %b expected %b", c, bus.w_en, exp_we); end
            checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL mid_grant c=%0d: got %b expected %b", c, bus.grant, exp_g); end
            step();
        end
        w_rst = 1'b1;
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.w_en !== 1'b0) begin errors++; $display("FAIL mid_rst_w_en: got %b expected 0", bus.w_en); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.word_count !== 16'd6) begin errors++; $display("FAIL mid_pre_count: got %0d expected 6", bus.word_count); end
        step();
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL mid_post_grant: got %b expected 0000", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_post_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.word_count !== 16'd0) begin errors++; $display("FAIL mid_post_count: got %0d expected 0", bus.word_count); end
        w_rst = 1'b0;
        bus.req_valid = 4'b0110;
        #1;
        checks++; if (bus.w_en !== 1'b0) begin errors++; $display("FAIL mid_idle_w_en: got %b expected 0", bus.w_en); end
        step();
        checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL mid_rr_ptr_grant: got %b expected 0010", bus.grant); end
        checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL mid_rr_ptr_id: got %0d expected 1", bus.grant_id); end
        bus.req_valid = '0;
    endtask

    // CNT_W=4 instance: 20 writes saturate the counter at 4'hF.
    task automatic test_saturate();
        int wr;
        logic exp_we;
        logic [3:0] exp_cnt;
        rst4 = 1'b1;
        bus4.req_valid = '0;
        bus4.req_data  = 32'h0000_0077;
        bus4.flag_full = 1'b0;
        step();
        step();
        rst4 = 1'b0;
        wr = 0;
        for (int c = 0; c < 25; c++) begin
            bus4.req_valid = 4'b0001;
            #1;
            exp_we  = (c % 5) != 0;
            exp_cnt = (wr > 15) ? 4'hF : 4'(wr);
            checks++; if (bus4.w_en !== exp_we) begin errors++; $display("FAIL sat_w_en c=%0d: got %b expected %b", c, bus4.w_en, exp_we); end
            checks++; if (bus4.word_count !== exp_cnt) begin errors++; $display("FAIL sat_count c=%0d: got %h expected %h", c, bus4.word_count, exp_cnt); end
            if (exp_we) wr++;
            step();
        end
        bus4.req_valid = '0;
        #1;
        checks++; if (bus4.word_count !== 4'hF) begin errors++; $display("FAIL sat_final: got %h expected f", bus4.word_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        w_rst = 1'b1;
        rst4  = 1'b1;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.flag_full  = 1'b0;
        bus4.req_valid = '0;
        bus4.req_data  = '0;
        bus4.flag_full = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_early_release();
        test_reset_mid_burst();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
